// File: rtl/request_aging_priority_gen_pkg.sv
// Shared arbiter helpers: saturating priority add, counter width
// and packed-field indexing.
package request_aging_priority_gen_pkg;

    localparam int DEF_AGE_THRESHOLD = 8;
    localparam int CNT_W = $clog2(DEF_AGE_THRESHOLD);

    // Add a boost to a base priority, clamping at the field maximum
    function automatic int unsigned sat_add(
        input int unsigned base,
        input int unsigned boost,
        input int unsigned width
    );
        int unsigned max_v;
        int unsigned sum;
        max_v = (32'd1 << width) - 32'd1;
        sum   = base + boost;
        return (sum > max_v) ? max_v : sum;
    endfunction

    // Low bit of packed field idx when each field is width bits wide
    function automatic int unsigned fld_lo(
        input int unsigned idx,
        input int unsigned width
    );
        return idx * width;
    endfunction

endpackage

// File: rtl/request_aging_priority_gen_age_counter_cell.sv
// One requester's aging state: wait counter, boost level and
// starvation flag, cleared by a grant or a dropped request.
module age_counter_cell
    import request_aging_priority_gen_pkg::*;
#(
    parameter int PRIORITY_WIDTH = 2,
    parameter int AGE_THRESHOLD  = DEF_AGE_THRESHOLD,
    parameter int MAX_BOOST      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      clr,
    output logic [PRIORITY_WIDTH-1:0] boost,
    output logic                      starved
);

    localparam int CW = $clog2(AGE_THRESHOLD);
    localparam logic [CW-1:0] CNT_LAST = CW'(AGE_THRESHOLD - 1);
    localparam logic [PRIORITY_WIDTH-1:0] BOOST_MAX = PRIORITY_WIDTH'(MAX_BOOST);

    logic [CW-1:0]             wait_cnt;
    logic [CW-1:0]             cnt_nxt;
    logic [PRIORITY_WIDTH-1:0] boost_q;
    logic [PRIORITY_WIDTH-1:0] boost_nxt;
    logic                      starved_q;

    // Next-state: grant clears first, then idle clears, else age
    always_comb begin
        cnt_nxt   = wait_cnt;
        boost_nxt = boost_q;
        if (clr || !req) begin
            cnt_nxt   = '0;
            boost_nxt = '0;
        end else if (wait_cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (boost_q < BOOST_MAX) begin
                boost_nxt = boost_q + PRIORITY_WIDTH'(1);
            end
        end else begin
            cnt_nxt = wait_cnt + CW'(1);
        end
    end

    // Aging registers; starved tracks the boost being written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            boost_q   <= '0;
            starved_q <= 1'b0;
        end else begin
            wait_cnt  <= cnt_nxt;
            boost_q   <= boost_nxt;
            starved_q <= (boost_nxt == BOOST_MAX);
        end
    end

    assign boost   = boost_q;
    assign starved = starved_q;

endmodule

// File: rtl/request_aging_priority_gen.sv
// Raises effective arbiter priority of requesters that wait too
// long; grants and dropped requests reset the aging.
module request_aging_priority_gen
    import request_aging_priority_gen_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int PRIORITY_WIDTH = 2,
    parameter int AGE_THRESHOLD  = DEF_AGE_THRESHOLD,
    parameter int MAX_BOOST      = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQUESTERS-1:0]              request,
    input  logic [NUM_REQUESTERS*PRIORITY_WIDTH-1:0] base_priority,
    input  logic [NUM_REQUESTERS-1:0]              grant,
    input  logic                                   grant_valid,
    output logic [NUM_REQUESTERS*PRIORITY_WIDTH-1:0] priorities,
    output logic [NUM_REQUESTERS-1:0]              starved,
    output logic [NUM_REQUESTERS*PRIORITY_WIDTH-1:0] boost_level
);

    localparam int PW = PRIORITY_WIDTH;

    logic [NUM_REQUESTERS-1:0] clr;

    assign clr = grant_valid ? grant : '0;

    for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_req
        localparam int LO = fld_lo(i, PW);

        logic [PW-1:0] boost_f;
        logic [PW-1:0] base_f;

        age_counter_cell #(
            .PRIORITY_WIDTH(PW),
            .AGE_THRESHOLD (AGE_THRESHOLD),
            .MAX_BOOST     (MAX_BOOST)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .req    (request[i]),
            .clr    (clr[i]),
            .boost  (boost_f),
            .starved(starved[i])
        );

        assign base_f = base_priority[LO +: PW];

        // Effective priority: base plus boost, never wrapping
        always_comb begin
            priorities[LO +: PW] =
                PW'(sat_add(32'(base_f), 32'(boost_f), PW));
        end

        assign boost_level[LO +: PW] = boost_f;
    end

endmodule
